writeback_unit: RTL and testbench

- Write-back stage of the single-issue MIPS datapath; the writer end of the register-file interface that Decode reads.
- Accepts completed results from execute and performs word loads through a simple request/acknowledge memory port.
- Drives write_reg_flag / write_reg / write_data into Banco_registros.
- Exports pending-destination information so Decode can stall on load-use hazards.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/wb_timeout_counter.sv | 48 ++++
 rtl/writeback_unit.sv | 173 +++++++++++++++++
 tb/tb_writeback_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the single-issue MIPS datapath write-back slice:
// register-file index/data widths, the special register indices and the
// write-back FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int REG_W            = 5;
  localparam int DATA_W           = 32;
  localparam int LINK_REG_DEFAULT = 31;

  // Wide enough for any timeout up to 255 cycles.
  localparam int CNT_W = 8;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// -----------------------------------------------------------------------------
// wb_timeout_counter
// Counts cycles spent waiting for a memory acknowledge and flags the last
// cycle the write-back stage is allowed to wait.
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-high reset (count -> 0)
//   clear   in   restart the count at zero (has priority over enable)
//   enable  in   advance the count by one
//   tc      out  count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module wb_timeout_counter
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
// Write-back stage of the single-issue MIPS datapath. Retires ALU and jal
// results straight into the register file and performs word loads through a
// request/acknowledge memory port, exporting the in-flight load destination
// so Decode can stall on load-use hazards.
// Ports:
//   clk, reset                 clock / asynchronous active-high reset
//   in_valid, in_ready         handshake with execute (ready only in IDLE)
//   in_reg_write, in_is_load,
//   in_link, in_dest,
//   in_alu_result, in_pc_4     completed-instruction fields from execute
//   mem_req, mem_addr          load request (held until ack or timeout)
//   mem_ack, mem_rdata         load response
//   write_reg_flag, write_reg,
//   write_data                 register-file write port (one-cycle strobe)
//   pend_valid, pend_reg       in-flight load destination for hazard stalls
//   mem_err                    sticky load-timeout flag
// -----------------------------------------------------------------------------
module writeback_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int LINK_REG       = LINK_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_is_load,
  input  logic              in_link,
  input  logic [REG_W-1:0]  in_dest,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_pc_4,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              write_reg_flag,
  output logic [REG_W-1:0]  write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              pend_valid,
  output logic [REG_W-1:0]  pend_reg,
  output logic              mem_err
);

  localparam logic [REG_W-1:0] LINK_IDX = REG_W'(LINK_REG);

  wb_state_e         state_q, state_d;
  logic              wr_flag_q, wr_flag_d;
  logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic [REG_W-1:0]  pend_reg_q, pend_reg_d;
  logic              mem_err_q, mem_err_d;

  logic              accept;
  logic              cnt_clear;
  logic              cnt_en;
  logic              cnt_tc;
  logic [REG_W-1:0]  eff_dest;
  logic [DATA_W-1:0] eff_data;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;

  // jal overrides both the destination and the data source.
  assign eff_dest = in_link ? LINK_IDX : in_dest;
  assign eff_data = in_link ? in_pc_4  : in_alu_result;

  always_comb begin
    state_d      = state_q;
    wr_flag_d    = 1'b0;
    wr_reg_d     = wr_reg_q;
    wr_data_d    = wr_data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pend_valid_d = pend_valid_q;
    pend_reg_d   = pend_reg_q;
    mem_err_d    = mem_err_q;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_is_load) begin
            mem_req_d    = 1'b1;
            mem_addr_d   = in_alu_result;
            pend_reg_d   = in_dest;
            pend_valid_d = (in_dest != REG_ZERO);
            cnt_clear    = 1'b1;
            state_d      = ST_LOAD_WAIT;
          end else if ((in_reg_write || in_link) && (eff_dest != REG_ZERO)) begin
            wr_flag_d = 1'b1;
            wr_reg_d  = eff_dest;
            wr_data_d = eff_data;
          end
        end
      end

      ST_LOAD_WAIT: begin
        // An ack on the terminal cycle still completes the load normally.
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          pend_valid_d = 1'b0;
          state_d      = ST_IDLE;
          if (pend_reg_q != REG_ZERO) begin
            wr_flag_d = 1'b1;
            wr_reg_d  = pend_reg_q;
            wr_data_d = mem_rdata;
          end
        end else if (cnt_tc) begin
          mem_req_d    = 1'b0;
          pend_valid_d = 1'b0;
          mem_err_d    = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_flag_q    <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_reg_q   <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_flag_q    <= wr_flag_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_reg_q   <= pend_reg_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign write_reg_flag = wr_flag_q;
  assign write_reg      = wr_reg_q;
  assign write_data     = wr_data_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign pend_valid     = pend_valid_q;
  assign pend_reg       = pend_reg_q;
  assign mem_err        = mem_err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
// Self-checking bench for writeback_unit (TIMEOUT_CYCLES=4). Directed steps
// followed by randomized transactions, each checked against a
// transaction-level model of the register-file write port and memory port.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic        in_is_load;
  logic        in_link;
  logic [4:0]  in_dest;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        write_reg_flag;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        pend_valid;
  logic [4:0]  pend_reg;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  // Model of the architecturally visible write-port and error state.
  logic [4:0]  exp_reg  = '0;
  logic [31:0] exp_data = '0;
  logic        exp_err  = 1'b0;

  writeback_unit #(.TIMEOUT_CYCLES(TO), .LINK_REG(31)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_reg_write   (in_reg_write),
    .in_is_load     (in_is_load),
    .in_link        (in_link),
    .in_dest        (in_dest),
    .in_alu_result  (in_alu_result),
    .in_pc_4        (in_pc_4),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .write_reg_flag (write_reg_flag),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .pend_valid     (pend_valid),
    .pend_reg       (pend_reg),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register-file port must show the model's held values with no strobe.
  task automatic chk_quiet(input string tag);
    chk({tag, "_flag"}, 32'(write_reg_flag), 32'd0);
    chk({tag, "_reg"},  32'(write_reg),      32'(exp_reg));
    chk({tag, "_data"}, write_data,          exp_data);
    chk({tag, "_err"},  32'(mem_err),        32'(exp_err));
  endtask

  task automatic do_idle();
    @(negedge clk);
    in_valid  = 1'b0;
    mem_ack   = 1'($urandom_range(0, 1));   // must be ignored outside a load
    mem_rdata = $urandom;
    @(posedge clk); #1;
    chk_quiet("idle");
    chk("idle_req",   32'(mem_req),    32'd0);
    chk("idle_pend",  32'(pend_valid), 32'd0);
    chk("idle_ready", 32'(in_ready),   32'd1);
  endtask

  task automatic do_alu(input logic rw, input logic link, input logic [4:0] dest,
                        input logic [31:0] alu, input logic [31:0] pc4);
    logic [4:0]  d;
    logic [31:0] v;
    logic        wr;
    @(negedge clk);
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_reg_write  = rw;
    in_link       = link;
    in_dest       = dest;
    in_alu_result = alu;
    in_pc_4       = pc4;
    mem_ack       = 1'($urandom_range(0, 1));
    mem_rdata     = $urandom;
    @(posedge clk); #1;
    d  = link ? 5'd31 : dest;
    v  = link ? pc4 : alu;
    wr = (rw || link) && (d != 5'd0);
    if (wr) begin
      exp_reg  = d;
      exp_data = v;
    end
    chk("alu_flag",  32'(write_reg_flag), 32'(wr));
    chk("alu_reg",   32'(write_reg),      32'(exp_reg));
    chk("alu_data",  write_data,          exp_data);
    chk("alu_req",   32'(mem_req),        32'd0);
    chk("alu_ready", 32'(in_ready),       32'd1);
    chk("alu_err",   32'(mem_err),        32'(exp_err));
  endtask

  // waits = number of ack-less cycles before the ack; waits >= TO means the
  // load is never acknowledged and must time out after TO request cycles.
  task automatic do_load(input logic [4:0] dest, input logic [31:0] addr,
                         input int waits, input logic [31:0] rdata);
    logic ack;
    @(negedge clk);
    in_valid      = 1'b1;
    in_is_load    = 1'b1;
    in_reg_write  = 1'b1;
    in_link       = 1'b0;
    in_dest       = dest;
    in_alu_result = addr;
    mem_ack       = 1'b0;
    @(posedge clk); #1;
    chk("ld_req0",   32'(mem_req),    32'd1);
    chk("ld_addr0",  mem_addr,        addr);
    chk("ld_pv0",    32'(pend_valid), 32'(dest != 5'd0));
    chk("ld_pr0",    32'(pend_reg),   32'(dest));
    chk("ld_ready0", 32'(in_ready),   32'd0);
    chk_quiet("ld_start");
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      // New work offered while busy must not be taken.
      in_valid      = 1'($urandom_range(0, 1));
      in_is_load    = 1'($urandom_range(0, 1));
      in_dest       = 5'($urandom_range(1, 31));
      in_alu_result = $urandom;
      ack           = (c == waits + 1);
      mem_ack       = ack;
      mem_rdata     = ack ? rdata : $urandom;
      @(posedge clk); #1;
      if (ack) begin
        if (dest != 5'd0) begin
          exp_reg  = dest;
          exp_data = rdata;
        end
        chk("ld_flag",   32'(write_reg_flag), 32'(dest != 5'd0));
        chk("ld_reg",    32'(write_reg),      32'(exp_reg));
        chk("ld_data",   write_data,          exp_data);
        chk("ld_req",    32'(mem_req),        32'd0);
        chk("ld_pv",     32'(pend_valid),     32'd0);
        chk("ld_ready",  32'(in_ready),       32'd1);
        chk("ld_err",    32'(mem_err),        32'(exp_err));
        break;
      end else if (c == TO) begin
        exp_err = 1'b1;
        chk_quiet("ld_to");
        chk("ld_to_req",   32'(mem_req),    32'd0);
        chk("ld_to_pv",    32'(pend_valid), 32'd0);
        chk("ld_to_ready", 32'(in_ready),   32'd1);
      end else begin
        chk("ld_w_req",   32'(mem_req),    32'd1);
        chk("ld_w_addr",  mem_addr,        addr);
        chk("ld_w_pv",    32'(pend_valid), 32'(dest != 5'd0));
        chk("ld_w_pr",    32'(pend_reg),   32'(dest));
        chk("ld_w_ready", 32'(in_ready),   32'd0);
        chk_quiet("ld_w");
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_flag"},  32'(write_reg_flag), 32'd0);
    chk({tag, "_reg"},   32'(write_reg),      32'd0);
    chk({tag, "_data"},  write_data,          32'd0);
    chk({tag, "_req"},   32'(mem_req),        32'd0);
    chk({tag, "_addr"},  mem_addr,            32'd0);
    chk({tag, "_pv"},    32'(pend_valid),     32'd0);
    chk({tag, "_pr"},    32'(pend_reg),       32'd0);
    chk({tag, "_err"},   32'(mem_err),        32'd0);
    chk({tag, "_ready"}, 32'(in_ready),       32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_is_load = 1'b0;
    in_link = 1'b0; in_dest = '0; in_alu_result = '0; in_pc_4 = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;

    // ALU write, then one quiet cycle (single-cycle strobe).
    do_alu(1'b1, 1'b0, 5'd8, 32'h0000_0005, 32'h0);
    do_idle();
    // jal with in_dest=0 still goes to $31.
    do_alu(1'b0, 1'b1, 5'd0, 32'h1234_5678, 32'h0040_0010);
    // Back-to-back accepts.
    do_alu(1'b1, 1'b0, 5'd3, 32'hCAFE_0001, 32'h0);
    do_alu(1'b1, 1'b0, 5'd4, 32'hCAFE_0002, 32'h0);
    // Non-writing instruction and write to $0.
    do_alu(1'b0, 1'b0, 5'd7, 32'h5555_5555, 32'h0);
    do_alu(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    do_idle();

    // Load with 3 waits then ack (also the terminal-cycle ack case).
    do_load(5'd9, 32'h1000_0004, 3, 32'hDEAD_BEEF);
    do_idle();
    // Immediate ack (minimum latency) and a load to $0.
    do_load(5'd12, 32'h1000_0008, 0, 32'h0BAD_F00D);
    do_load(5'd0, 32'h1000_000C, 1, 32'h1111_2222);
    do_idle();
    // Timeout, error is sticky across later traffic.
    do_load(5'd10, 32'h2000_0000, TO, 32'h0);
    do_idle();
    do_alu(1'b1, 1'b0, 5'd5, 32'h0000_00AA, 32'h0);
    do_load(5'd11, 32'h2000_0004, TO - 1, 32'h7777_8888);
    do_idle();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [4:0] d;
      int kind;
      kind = int'($urandom_range(0, 3));
      d    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case (kind)
        0: do_alu(1'($urandom_range(0, 1)), 1'b0, d, $urandom, $urandom);
        1: do_load(d, $urandom, int'($urandom_range(0, TO)), $urandom);
        2: do_idle();
        default: do_alu(1'($urandom_range(0, 1)), 1'b1, d, $urandom, $urandom);
      endcase
    end

    // Asynchronous reset in the middle of a load.
    @(negedge clk);
    in_valid = 1'b1; in_is_load = 1'b1; in_dest = 5'd6; in_alu_result = 32'h3000_0000;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("mid_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    exp_reg = '0; exp_data = '0; exp_err = 1'b0;
    chk_reset_state("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    do_idle();
    do_alu(1'b1, 1'b0, 5'd2, 32'h0000_0042, 32'h0);
    do_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
